// File: rtl/sdram_arbiter_if.sv
// Port-side and controller-side bus bundle for sdram_arbiter.
// slave = arbiter view, master = clients plus SDRAM controller view.
interface sdram_arbiter_if #(parameter int NUM_PORTS = 2);
  logic [NUM_PORTS-1:0]       acc_i;
  logic [NUM_PORTS-1:0]       we_i;
  logic [NUM_PORTS-1:0][31:0] adr_i;
  logic [NUM_PORTS-1:0][15:0] dat_i;
  logic [NUM_PORTS-1:0][1:0]  sel_i;
  logic [NUM_PORTS-1:0]       ack_o;
  logic [15:0]                dat_o;
  logic [31:0]                adr_o;
  logic                       ctrl_acc_o;
  logic                       ctrl_we_o;
  logic [31:0]                ctrl_adr_o;
  logic [15:0]                ctrl_dat_o;
  logic [1:0]                 ctrl_sel_o;
  logic                       ctrl_ack_i;
  logic [15:0]                ctrl_dat_i;
  logic [31:0]                ctrl_adr_i;
  logic [NUM_PORTS-1:0]       grant_o;

  modport slave (
    input  acc_i, we_i, adr_i, dat_i, sel_i, ctrl_ack_i, ctrl_dat_i, ctrl_adr_i,
    output ack_o, dat_o, adr_o, ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o,
           ctrl_sel_o, grant_o
  );

  modport master (
    output acc_i, we_i, adr_i, dat_i, sel_i, ctrl_ack_i, ctrl_dat_i, ctrl_adr_i,
    input  ack_o, dat_o, adr_o, ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o,
           ctrl_sel_o, grant_o
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin SDRAM arbiter: one owner at a time, grant held for HOLD_CYCLES
// quiet cycles so back-to-back bursts from the same client stay atomic.
module sdram_arbiter_port #(
  parameter int IW  = 1,
  parameter int IDX = 0
) (
  input  logic          active,
  input  logic [IW-1:0] owner,
  input  logic          ctrl_ack,
  output logic          grant,
  output logic          ack
);
  assign grant = active && (owner == IW'(IDX));
  assign ack   = grant & ctrl_ack;
endmodule

module sdram_arbiter #(
  parameter int NUM_PORTS   = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic           sdram_clk,
  input  logic           sdram_rst,
  sdram_arbiter_if.slave bus
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, GRANTED, HOLD} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        owner, last_owner, pick;
  logic [3:0]           hold_cnt;
  logic                 found, owner_acc, hold_expired, active;
  logic [NUM_PORTS-1:0] grant_v, ack_v;

  assign owner_acc    = bus.acc_i[owner];
  assign hold_expired = (hold_cnt == 4'(HOLD_CYCLES - 1));
  assign active       = (state != IDLE);

  // Search upward from the port after the last owner so every requester is
  // reached within NUM_PORTS-1 grants.
  always_comb begin
    int idx;
    pick  = last_owner;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(last_owner) + i) % NUM_PORTS;
      if (!found && bus.acc_i[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(NUM_PORTS - 1);
      hold_cnt   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:    if (found) owner <= pick;
        GRANTED: hold_cnt <= '0;
        HOLD: if (!owner_acc) begin
          if (hold_expired) last_owner <= owner;
          else              hold_cnt   <= hold_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = GRANTED;
      GRANTED: if (!owner_acc) state_nxt = HOLD;
      HOLD: begin
        if (owner_acc)         state_nxt = GRANTED;
        else if (hold_expired) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ctrl_acc_o = 1'b0;
    bus.ctrl_we_o  = 1'b0;
    bus.ctrl_adr_o = '0;
    bus.ctrl_dat_o = '0;
    bus.ctrl_sel_o = '0;
    if (active) begin
      bus.ctrl_acc_o = bus.acc_i[owner];
      bus.ctrl_we_o  = bus.we_i[owner];
      bus.ctrl_adr_o = bus.adr_i[owner];
      bus.ctrl_dat_o = bus.dat_i[owner];
      bus.ctrl_sel_o = bus.sel_i[owner];
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    sdram_arbiter_port #(.IW(IW), .IDX(g)) u_port (
      .active   (active),
      .owner    (owner),
      .ctrl_ack (bus.ctrl_ack_i),
      .grant    (grant_v[g]),
      .ack      (ack_v[g])
    );
  end

  assign bus.grant_o = grant_v;
  assign bus.ack_o   = ack_v;
  // Read beats keep flowing to the clients even while the grant is parked.
  assign bus.dat_o   = bus.ctrl_dat_i;
  assign bus.adr_o   = bus.ctrl_adr_i;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random traffic checked
// against an ownership model (owner, last owner, run of quiet cycles).
module tb_sdram_arbiter;
  localparam int NP = 2;
  localparam int HC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Model: a grant is released after HC+1 consecutive cycles with the
  // owner's acc low (the cycle it drops, then HC cycles of hold).
  int m_owner = -1;
  int m_last  = NP - 1;
  int m_quiet = 0;

  sdram_arbiter_if #(.NUM_PORTS(NP)) bus ();

  sdram_arbiter #(.NUM_PORTS(NP), .HOLD_CYCLES(HC)) dut (
    .sdram_clk (clk),
    .sdram_rst (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_update();
    bit done;
    if (rst) begin
      m_owner = -1; m_last = NP - 1; m_quiet = 0;
    end else if (m_owner < 0) begin
      done = 0;
      for (int i = 1; i <= NP; i++) begin
        if (!done && bus.acc_i[(m_last + i) % NP]) begin
          m_owner = (m_last + i) % NP; m_quiet = 0; done = 1;
        end
      end
    end else if (bus.acc_i[m_owner]) begin
      m_quiet = 0;
    end else begin
      m_quiet++;
      if (m_quiet == HC + 1) begin
        m_last = m_owner; m_owner = -1; m_quiet = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    bus.acc_i = '0; bus.we_i = '0; bus.adr_i = '0; bus.dat_i = '0; bus.sel_i = '0;
    bus.ctrl_ack_i = 1'b0; bus.ctrl_dat_i = '0; bus.ctrl_adr_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.acc_i = 2'b11; bus.we_i = 2'b11; bus.ctrl_ack_i = 1'b1;
    tick(); tick(); #1;
    n_tests++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", bus.grant_o); end
    n_tests++; if (bus.ctrl_acc_o !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_acc: got %b want 0", bus.ctrl_acc_o); end
    n_tests++; if (bus.ctrl_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_we: got %b want 0", bus.ctrl_we_o); end
    n_tests++; if (bus.ack_o !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", bus.ack_o); end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    int n;
    bus.acc_i = 2'b10; bus.we_i = 2'b10;
    bus.adr_i[1] = 32'h0000_0100; bus.dat_i[1] = 16'hBEEF; bus.sel_i[1] = 2'b11;
    bus.adr_i[0] = 32'hDEAD_0000; bus.dat_i[0] = 16'h5555; bus.sel_i[0] = 2'b01;
    #1;
    n_tests++; if (bus.grant_o !== 2'b00 || bus.ctrl_acc_o !== 1'b0 || bus.ctrl_adr_o !== 32'h0)
      begin n_fail++; $display("FAIL sw_latency: got grant %b acc %b adr %h want 00 0 0", bus.grant_o, bus.ctrl_acc_o, bus.ctrl_adr_o); end
    tick(); #1;
    n_tests++; if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL sw_grant: got %b want 10", bus.grant_o); end
    n_tests++; if ({bus.ctrl_acc_o, bus.ctrl_we_o, bus.ctrl_adr_o, bus.ctrl_dat_o, bus.ctrl_sel_o} !== {1'b1, 1'b1, 32'h100, 16'hBEEF, 2'b11})
      begin n_fail++; $display("FAIL sw_ctrl_mux: got %b %b %h %h %b want 1 1 00000100 beef 11",
        bus.ctrl_acc_o, bus.ctrl_we_o, bus.ctrl_adr_o, bus.ctrl_dat_o, bus.ctrl_sel_o); end
    n_tests++; if (bus.ack_o !== 2'b00) begin n_fail++; $display("FAIL sw_no_ack: got %b want 00", bus.ack_o); end
    tick(); tick();
    bus.ctrl_ack_i = 1'b1; #1;
    n_tests++; if (bus.ack_o !== 2'b10) begin n_fail++; $display("FAIL sw_ack: got %b want 10", bus.ack_o); end
    tick();
    bus.ctrl_ack_i = 1'b0; bus.acc_i = '0; bus.we_i = '0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.grant_o === 2'b00) break;
      n++;
      tick();
    end
    n_tests++; if (n != HC + 1) begin n_fail++; $display("FAIL sw_hold_len: got %0d want %0d cycles", n, HC + 1); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1; clear_inputs(); tick(); rst = 1'b0;
    bus.acc_i = 2'b11; tick(); #1;
    n_tests++; if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL rr_first: got %b want 01", bus.grant_o); end
    bus.acc_i = 2'b10;
    for (int c = 0; c < 40; c++) begin #1; if (bus.grant_o !== 2'b01) break; tick(); end
    tick(); #1;
    n_tests++; if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL rr_second: got %b want 10", bus.grant_o); end
    bus.acc_i = 2'b00;
    for (int c = 0; c < 40; c++) begin #1; if (bus.grant_o === 2'b00) break; tick(); end
    bus.acc_i = 2'b11; tick(); #1;
    n_tests++; if (bus.grant_o !== 2'b01) begin n_fail++; $display("FAIL rr_third: got %b want 01", bus.grant_o); end
  endtask

  task automatic test_refill_hold();
    int bad, n;
    rst = 1'b1; clear_inputs(); tick(); rst = 1'b0;
    bus.acc_i = 2'b01; tick();
    bus.ctrl_ack_i = 1'b1; #1;
    n_tests++; if (bus.ack_o !== 2'b01) begin n_fail++; $display("FAIL rf_ack: got %b want 01", bus.ack_o); end
    tick();
    bus.ctrl_ack_i = 1'b0; bus.acc_i = 2'b10;
    bad = 0;
    for (int c = 0; c < 3; c++) begin #1; if (bus.grant_o !== 2'b01) bad++; tick(); end
    bus.acc_i = 2'b11;
    for (int c = 0; c < 2; c++) begin #1; if (bus.grant_o !== 2'b01) bad++; tick(); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rf_atomic: got %0d cycles without grant 01 want 0", bad); end
    bus.acc_i = 2'b10;
    n = 0;
    for (int c = 0; c < 40; c++) begin #1; if (bus.grant_o !== 2'b01) break; n++; tick(); end
    n_tests++; if (n != HC + 1) begin n_fail++; $display("FAIL rf_quiet: got %0d cycles want %0d", n, HC + 1); end
    n_tests++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL rf_idle: got %b want 00", bus.grant_o); end
    tick(); #1;
    n_tests++; if (bus.grant_o !== 2'b10) begin n_fail++; $display("FAIL rf_next: got %b want 10", bus.grant_o); end
  endtask

  task automatic test_stray_ack();
    bus.acc_i = '0;
    for (int c = 0; c < 40; c++) begin #1; if (bus.grant_o === 2'b00) break; tick(); end
    bus.ctrl_ack_i = 1'b1; bus.ctrl_dat_i = 16'h1234; bus.ctrl_adr_i = 32'hCAFE_0040; #1;
    n_tests++; if (bus.ack_o !== 2'b00) begin n_fail++; $display("FAIL stray_ack: got %b want 00", bus.ack_o); end
    n_tests++; if (bus.dat_o !== 16'h1234) begin n_fail++; $display("FAIL stray_dat: got %h want 1234", bus.dat_o); end
    n_tests++; if (bus.adr_o !== 32'hCAFE_0040) begin n_fail++; $display("FAIL stray_adr: got %h want cafe0040", bus.adr_o); end
    bus.ctrl_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.acc_i = 2'b01; tick(); #1;
    n_tests++; if (bus.grant_o === 2'b00) begin n_fail++; $display("FAIL rmb_setup: got %b want nonzero", bus.grant_o); end
    rst = 1'b1; bus.acc_i = 2'b00; tick(); rst = 1'b0;
    bus.ctrl_ack_i = 1'b1; #1;
    n_tests++; if (bus.grant_o !== 2'b00 || bus.ctrl_acc_o !== 1'b0)
      begin n_fail++; $display("FAIL rmb_abort: got grant %b acc %b want 00 0", bus.grant_o, bus.ctrl_acc_o); end
    n_tests++; if (bus.ack_o !== 2'b00) begin n_fail++; $display("FAIL rmb_ack0: got %b want 00", bus.ack_o); end
    tick(); #1;
    n_tests++; if (bus.ack_o !== 2'b00) begin n_fail++; $display("FAIL rmb_ack1: got %b want 00", bus.ack_o); end
    bus.ctrl_ack_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [NP-1:0] e_grant, e_ack;
    logic [50:0]   e_ctrl, a_ctrl;
    rst = 1'b1; clear_inputs(); tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(4) == 0) bus.acc_i[p] = ~bus.acc_i[p];
        bus.we_i[p]  = 1'($urandom);
        bus.adr_i[p] = $urandom;
        bus.dat_i[p] = 16'($urandom);
        bus.sel_i[p] = 2'($urandom);
      end
      bus.ctrl_ack_i = ($urandom_range(2) == 0);
      bus.ctrl_dat_i = 16'($urandom);
      bus.ctrl_adr_i = $urandom;
      rst = ($urandom_range(299) == 0);
      #1;
      e_grant = '0; e_ack = '0; e_ctrl = '0;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        e_ack[m_owner]   = bus.ctrl_ack_i;
        e_ctrl = {bus.acc_i[m_owner], bus.we_i[m_owner], bus.adr_i[m_owner], bus.dat_i[m_owner], bus.sel_i[m_owner]};
      end
      a_ctrl = {bus.ctrl_acc_o, bus.ctrl_we_o, bus.ctrl_adr_o, bus.ctrl_dat_o, bus.ctrl_sel_o};
      n_tests++; if (bus.grant_o !== e_grant) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b want %b", c, bus.grant_o, e_grant); end
      n_tests++; if (bus.ack_o !== e_ack) begin n_fail++; $display("FAIL rnd_ack c%0d: got %b want %b", c, bus.ack_o, e_ack); end
      n_tests++; if (a_ctrl !== e_ctrl) begin n_fail++; $display("FAIL rnd_ctrl c%0d: got %h want %h", c, a_ctrl, e_ctrl); end
      n_tests++; if (bus.dat_o !== bus.ctrl_dat_i || bus.adr_o !== bus.ctrl_adr_i)
        begin n_fail++; $display("FAIL rnd_bcast c%0d: got %h/%h want %h/%h", c, bus.dat_o, bus.adr_o, bus.ctrl_dat_i, bus.ctrl_adr_i); end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_refill_hold();
    test_stray_ack();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, range 2..8: number of wb_port-style clients.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, range 2..15: idle cycles the grant is kept after the owner drops acc.
REQ-003 SHALL have sdram_clk  in  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have sdram_rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port-side acc_i  in  NUM_PORTS  per-port access request, bit n belongs to port n.
REQ-006 SHALL have port-side we_i  in  NUM_PORTS  per-port write enable.
REQ-007 SHALL have port-side adr_i  in  32*NUM_PORTS  per-port address, port n in bits [32n+31:32n].
REQ-008 SHALL have port-side dat_i  in  16*NUM_PORTS  per-port write data, port n in bits [16n+15:16n].
REQ-009 SHALL have port-side sel_i  in  2*NUM_PORTS  per-port byte selects, port n in bits [2n+1:2n].
REQ-010 SHALL have port-side ack_o  out  NUM_PORTS  per-port acknowledge.
REQ-011 SHALL have port-side dat_o  out  16  read data broadcast to all ports.
REQ-012 SHALL have port-side adr_o  out  32  current beat address broadcast to all ports.
REQ-013 SHALL have controller-side ctrl_acc_o, ctrl_we_o  out  1 each  muxed request and write enable.
REQ-014 SHALL have controller-side ctrl_adr_o  out  32, ctrl_dat_o  out  16, ctrl_sel_o  out  2  muxed from the owner.
REQ-015 SHALL have controller-side ctrl_ack_i  in  1, ctrl_dat_i  in  16, ctrl_adr_i  in  32  from the SDRAM controller.
REQ-016 SHALL have grant_o  out  NUM_PORTS  one-hot current owner, all zero when no owner.

Function
REQ-017 SHALL implement states IDLE, GRANTED, HOLD in a registered state machine, plus a registered owner index and last-owner index.
REQ-018 In IDLE, if any acc_i bit is set, SHALL select the first requesting port searching upward from last_owner+1 (mod NUM_PORTS), register it as owner and go to GRANTED the next cycle.
REQ-019 Grant latency SHALL be exactly one cycle: acc_i[n] high at edge k from IDLE -> ctrl_acc_o high during cycle k+1.
REQ-020 In GRANTED, when acc_i[owner] is low, SHALL go to HOLD and clear the hold counter.
REQ-021 In HOLD, if acc_i[owner] rises, SHALL return to GRANTED with no re-arbitration. This keeps a two-burst refill atomic.
REQ-022 In HOLD, the counter SHALL increment each cycle. At count HOLD_CYCLES-1 with owner acc low, SHALL go to IDLE and set last_owner to owner.
REQ-023 Requests from non-owners SHALL be ignored until IDLE, then arbitrated round-robin per REQ-018. No starvation: each requester waits at most NUM_PORTS-1 grants.
REQ-024 In GRANTED and HOLD, ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o and ctrl_sel_o SHALL combinationally equal the owner's inputs.
REQ-025 In IDLE, ctrl_acc_o and ctrl_we_o SHALL be 0; ctrl_adr_o, ctrl_dat_o and ctrl_sel_o SHALL be 0.
REQ-026 ack_o[owner] SHALL combinationally equal ctrl_ack_i in GRANTED and HOLD; all other ack_o bits SHALL be 0.
REQ-027 In IDLE, all ack_o bits SHALL be 0, even if ctrl_ack_i is high (stray ack dropped).
REQ-028 dat_o SHALL equal ctrl_dat_i and adr_o SHALL equal ctrl_adr_i in every state, unregistered, so read beats after ack continue through HOLD.
REQ-029 grant_o SHALL be the one-hot decode of owner in GRANTED and HOLD, and zero in IDLE.
REQ-030 If several ports raise acc_i simultaneously in IDLE, exactly one SHALL be granted, per REQ-018.

Reset
REQ-031 On sdram_rst high at a clock edge, the next state SHALL be IDLE, last_owner NUM_PORTS-1 (port 0 wins first), and the hold counter 0.
REQ-032 After reset, all outputs SHALL read: ctrl_acc_o=0, ctrl_we_o=0, ack_o=0, grant_o=0.
REQ-033 Reset asserted mid-GRANTED or mid-HOLD SHALL abort the grant in the following cycle; no ack_o SHALL reach the aborted port afterwards.

Verification
REQ-034 Single write: NUM_PORTS=2, port1 acc/we high with adr 0x100, dat 0xBEEF, sel 2'b11; ctrl_ack_i pulses 3 cycles later -> ctrl outputs match, ack_o=2'b10 for that cycle, back to IDLE after 8 idle cycles.
REQ-035 Simultaneous request after reset: acc_i=2'b11 -> port0 granted first; after release, port1 granted; a third contest grants port0 again.
REQ-036 Refill hold: port0 acc drops on ack, re-raises 3 cycles later while port1 requests -> grant_o stays 2'b01 throughout; port1 is granted only after 8 quiet cycles.
REQ-037 Hold expiry: with HOLD_CYCLES=8, owner idle -> IDLE entered on the 8th HOLD cycle; a pending request is granted with 1-cycle latency.
REQ-038 Stray ack: ctrl_ack_i=1 in IDLE -> ack_o=0; ctrl_dat_i=0x1234 still appears on dat_o.
REQ-039 Reset mid-burst: assert sdram_rst during GRANTED -> next cycle grant_o=0, ctrl_acc_o=0; subsequent ctrl_ack_i is not forwarded.
